// File: rtl/data_bus_responder.sv
// Data-memory bus responder: word RAM plus a small peripheral window
// holding a cycle counter, a byte transmit FIFO and a halt register.
module data_bus_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int IW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] RAM_END  = 32'(RAM_WORDS * 4);
  localparam logic [31:0] MMIO_END = MMIO_BASE + 32'd16;
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_inc;
  logic [CW-1:0] count;
  logic [31:0]   cycle;
  logic          overflow;

  logic [31:0]   moff;
  logic [IW-1:0] ram_idx;
  logic          is_ram;
  logic          is_mmio;
  logic          sel_cyc;
  logic          sel_txd;
  logic          sel_sts;
  logic          sel_hlt;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic [7:0]    cnt8;
  logic [31:0]   status;
  logic          unused;

  assign is_ram  = a < RAM_END;
  assign is_mmio = (a >= MMIO_BASE) && (a < MMIO_END);
  assign moff    = a - MMIO_BASE;
  assign ram_idx = a[IW+1:2];

  assign sel_cyc = is_mmio && (moff[3:2] == 2'd0);
  assign sel_txd = is_mmio && (moff[3:2] == 2'd1);
  assign sel_sts = is_mmio && (moff[3:2] == 2'd2);
  assign sel_hlt = is_mmio && (moff[3:2] == 2'd3);

  assign empty    = (count == '0);
  assign full     = (count == DEPTH);
  assign tx_valid = !empty;
  assign pop      = tx_valid && tx_ready;
  assign push_req = we && sel_txd;
  // A full FIFO still takes a byte when the head leaves on the same edge
  assign push_ok  = push_req && (!full || pop);

  assign rd_ptr_inc = rd_ptr + PW'(1);
  assign cnt8       = 8'(count);
  assign status     = {16'd0, cnt8, 5'd0, overflow, full, empty};
  assign unused     = ^{moff[31:4], moff[1:0]};

  always_comb begin
    rd = '0;
    unique case (1'b1)
      is_ram:  rd = ram[ram_idx];
      sel_cyc: rd = cycle;
      sel_txd: rd = '0;
      sel_sts: rd = status;
      sel_hlt: rd = {31'd0, halt};
      default: rd = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (we && is_ram) begin
      ram[ram_idx] <= wd;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo[wr_ptr] <= wd[7:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      count <= count + CW'(push_ok) - CW'(pop);
      // The pushed byte becomes head only when nothing else remains
      if (push_ok && ((count - CW'(pop)) == '0)) begin
        tx_data <= wd[7:0];
      end else if (pop && (count > CW'(1))) begin
        tx_data <= fifo[rd_ptr_inc];
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (we && sel_sts && wd[2]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle     <= '0;
      halt      <= 1'b0;
      halt_code <= '0;
    end else begin
      if (!halt) begin
        cycle <= cycle + 32'd1;
      end
      if (we && sel_hlt && !halt) begin
        halt      <= 1'b1;
        halt_code <= wd;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: vector table for RAM and
// FIFO drain, hand sequences for counter, halt, overflow and reset.
module tb_data_bus_responder;

  localparam logic [31:0] MB = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic        tx_ready = 1'b0;
  logic [31:0] rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        halt;
  logic [31:0] halt_code;

  int checks = 0;
  int errors = 0;

  data_bus_responder dut (
    .clock(clock),
    .reset(reset),
    .we(we),
    .a(a),
    .wd(wd),
    .rd(rd),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .halt(halt),
    .halt_code(halt_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_tx;
    logic        exp_valid;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] addr,
                       input logic [31:0] d, input logic r);
    @(negedge clock);
    we = w;
    a = addr;
    wd = d;
    tx_ready = r;
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic w,
      input logic [31:0] ad, input logic [31:0] d, input logic r,
      input logic cr, input logic [31:0] er, input logic ct,
      input logic ev, input logic [7:0] ed);
    vec_t v;
    v.name = n; v.we = w; v.a = ad; v.wd = d; v.rdy = r;
    v.chk_rd = cr; v.exp_rd = er; v.chk_tx = ct;
    v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  initial begin
    vt[0]  = mk("ram_w55",   1, 32'h60, 32'h55, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk("ram_w19",   1, 32'h60, 32'h19, 0, 1, 32'h55, 0, 0, 0);
    vt[2]  = mk("ram_r60",   0, 32'h60, 0, 0, 1, 32'h19, 0, 0, 0);
    vt[3]  = mk("unmap_r",   0, 32'h800, 0, 0, 1, 0, 0, 0, 0);
    vt[4]  = mk("ram_r63",   0, 32'h63, 0, 0, 1, 32'h19, 0, 0, 0);
    vt[5]  = mk("ram_w0",    1, 32'h0, 32'h1111_1111, 0, 0, 0, 0, 0, 0);
    vt[6]  = mk("unmap_w",   1, 32'h800, 32'hDEAD, 0, 1, 0, 0, 0, 0);
    vt[7]  = mk("ram_r0",    0, 32'h0, 0, 0, 1, 32'h1111_1111, 0, 0, 0);
    vt[8]  = mk("push41",    1, MB+4, 32'h41, 0, 1, 0, 1, 0, 8'h00);
    vt[9]  = mk("push42",    1, MB+4, 32'h42, 0, 1, 0, 1, 1, 8'h41);
    vt[10] = mk("push43",    1, MB+4, 32'h43, 0, 1, 0, 1, 1, 8'h41);
    vt[11] = mk("sts3",      0, MB+8, 0, 0, 1, 32'h300, 1, 1, 8'h41);
    vt[12] = mk("pop41",     0, MB+8, 0, 1, 1, 32'h300, 1, 1, 8'h41);
    vt[13] = mk("pop42",     0, MB+8, 0, 1, 1, 32'h200, 1, 1, 8'h42);
    vt[14] = mk("pop43",     0, MB+8, 0, 1, 1, 32'h100, 1, 1, 8'h43);
    vt[15] = mk("drained",   0, MB+8, 0, 1, 1, 32'h001, 1, 0, 8'h43);

    a = MB + 8;
    #1;
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_halt", 32'(halt), 0);
    chk("rst_code", halt_code, 0);
    chk("rst_sts", rd, 32'h1);

    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(posedge clock);
    drive(0, MB, 0, 0);
    chk("cycle10", rd, 32'd10);
    drive(1, MB+12, 32'h19, 0);
    drive(0, MB, 0, 0);
    chk("halt_set", 32'(halt), 1);
    chk("halt_code", halt_code, 32'h19);
    chk("cycle12", rd, 32'd12);
    drive(1, MB+12, 32'h7, 0);
    drive(0, MB, 0, 0);
    chk("cycle_frz", rd, 32'd12);
    chk("code_keep", halt_code, 32'h19);
    drive(0, MB+12, 0, 0);
    chk("halt_rd", rd, 32'h1);

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].we, vt[i].a, vt[i].wd, vt[i].rdy);
      if (vt[i].chk_rd) chk(vt[i].name, rd, vt[i].exp_rd);
      if (vt[i].chk_tx) begin
        chk({vt[i].name, "_v"}, 32'(tx_valid), 32'(vt[i].exp_valid));
        chk({vt[i].name, "_d"}, 32'(tx_data), 32'(vt[i].exp_data));
      end
    end

    for (int i = 0; i < 9; i++) begin
      drive(1, MB+4, 32'(i), 0);
    end
    drive(0, MB+8, 0, 0);
    chk("full_sts", rd, 32'h806);
    chk("full_data", 32'(tx_data), 0);
    drive(1, MB+8, 32'h4, 0);
    chk("ovf_pre", rd, 32'h806);
    drive(0, MB+8, 0, 0);
    chk("ovf_clr", rd, 32'h802);
    drive(1, MB+4, 32'hAA, 1);
    chk("pp_data", 32'(tx_data), 0);
    drive(0, MB+8, 0, 0);
    chk("pp_sts", rd, 32'h802);
    chk("pp_head", 32'(tx_data), 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, MB+8, 0, 1);
      chk("dr_sts", rd, ((32'(8 - i)) << 8) | ((i == 0) ? 32'h2 : 32'h0));
      chk("dr_data", 32'(tx_data), (i < 7) ? 32'(i + 1) : 32'hAA);
    end
    drive(0, MB+8, 0, 0);
    chk("dr_empty", rd, 32'h1);
    chk("dr_valid", 32'(tx_valid), 0);

    for (int i = 0; i < 5; i++) begin
      drive(1, MB+4, 32'h50 + 32'(i), 0);
    end
    drive(0, MB+8, 0, 0);
    chk("q5_sts", rd, 32'h500);
    chk("q5_valid", 32'(tx_valid), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(tx_valid), 0);
    chk("ar_data", 32'(tx_data), 0);
    chk("ar_halt", 32'(halt), 0);
    chk("ar_code", halt_code, 0);
    chk("ar_sts", rd, 32'h1);
    a = MB;
    #1;
    chk("ar_cycle", rd, 0);
    reset = 1'b0;
    drive(0, 32'h60, 0, 0);
    chk("ar_ram", rd, 32'h19);
    drive(0, MB, 0, 0);
    chk("ar_cyc2", rd, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
